// File: rtl/sram_mem_ctrl_if.sv
// sram_mem_ctrl_if - bundle between the MEM stage / SRAM pins and sram_mem_ctrl.
//   CPU side : wr_en, rd_en, address[31:0], write_data[31:0] -> controller
//              read_data[31:0], ready                          <- controller
//   SRAM side: sram_addr[17:0], sram_dq_out[15:0], sram_dq_oe, sram_we_n <- controller
//              sram_dq_in[15:0]                                -> controller
//   modport slave  : the controller
//   modport master : the CPU pipeline plus SRAM pad model (everything else)
interface sram_mem_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl - splits one 32-bit load/store into two 16-bit accesses on an
// asynchronous SRAM, freezing the pipeline (ready=0) until the word is done.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset, aborts any access in flight
//   bus  : sram_mem_ctrl_if.slave (CPU request/response + SRAM pins)
// Parameters:
//   WAIT_CYCLES : cycles each half-word access is held, 1..15
//   BASE_ADDR   : CPU byte address that maps to SRAM word 0
// Optional build macro SRAM_READ_CACHE_EN adds a one-entry write-through read
// cache; read hits complete in the request cycle with no SRAM access.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int BASE_ADDR   = 1024
) (
  input logic          clk,
  input logic          rst,
  sram_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  // With a single-cycle access the only cycle is also the data-hold cycle,
  // so the strobe never goes low.
  localparam logic FIRST_WE_N = (WAIT_CYCLES == 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [16:0] op_word;
  logic [31:0] op_data;
  logic [31:0] rd_q;
  logic [17:0] addr_q;
  logic [15:0] dq_out_q;
  logic        oe_q;
  logic        we_n_q;

  logic [31:0] req_off;
  logic [29:0] req_word;
  logic        req;
  logic        hit;

  assign req_off  = bus.address - 32'(BASE_ADDR);
  assign req_word = req_off[31:2];
  assign req      = bus.wr_en | bus.rd_en;

  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_we_n   = we_n_q;

  // IDLE answers combinationally so an idle pipeline never stalls.
  assign bus.ready = (state == IDLE) ? (~req | hit) : (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      op_word  <= '0;
      op_data  <= '0;
      rd_q     <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      we_n_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            // Write wins when both enables are set.
            op_wr   <= bus.wr_en;
            op_word <= req_word[16:0];
            op_data <= bus.write_data;
            cnt     <= '0;
            state   <= LOW;
            addr_q  <= {req_word[16:0], 1'b0};
            if (bus.wr_en) begin
              dq_out_q <= bus.write_data[15:0];
              oe_q     <= 1'b1;
              we_n_q   <= FIRST_WE_N;
            end else begin
              oe_q   <= 1'b0;
              we_n_q <= 1'b1;
            end
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            cnt    <= '0;
            state  <= HIGH;
            addr_q <= {op_word, 1'b1};
            if (op_wr) begin
              dq_out_q <= op_data[31:16];
              we_n_q   <= FIRST_WE_N;
            end else begin
              rd_q[15:0] <= bus.sram_dq_in;
            end
          end else begin
            cnt <= cnt + 4'd1;
            // Strobe rises for the last cycle so data is held past we_n.
            if (op_wr) we_n_q <= (4'(cnt + 4'd1) == LAST);
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            cnt    <= '0;
            state  <= DONE;
            oe_q   <= 1'b0;
            we_n_q <= 1'b1;
            if (!op_wr) rd_q[31:16] <= bus.sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
            if (op_wr) we_n_q <= (4'(cnt + 4'd1) == LAST);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_READ_CACHE_EN
  logic        c_vld;
  logic [29:0] c_tag;
  logic [31:0] c_data;
  logic [29:0] op_tag;
  logic        unused_bits;

  assign unused_bits = ^req_off[1:0];
  assign hit = bus.rd_en & ~bus.wr_en & c_vld & (c_tag == req_word);
  assign bus.read_data = (state == IDLE && hit) ? c_data : rd_q;

  // Entry is updated in DONE, when rd_q holds the full word and a write has
  // fully reached the SRAM; an aborted access never touches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld  <= 1'b0;
      c_tag  <= '0;
      c_data <= '0;
      op_tag <= '0;
    end else begin
      if (state == IDLE && req && !hit) op_tag <= req_word;
      if (state == DONE) begin
        if (!op_wr) begin
          c_vld  <= 1'b1;
          c_tag  <= op_tag;
          c_data <= rd_q;
        end else if (c_vld && c_tag == op_tag) begin
          c_data <= op_data;
        end
      end
    end
  end
`else
  logic unused_bits;

  assign unused_bits   = ^{req_off[1:0], req_word[29:17]};
  assign hit           = 1'b0;
  assign bus.read_data = rd_q;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;
  localparam int W   = 4;
  localparam int LAT = 2 * W + 1;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  sram_mem_ctrl_if bif ();

  sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Async SRAM model: a write is captured while we_n is low and committed when
  // we_n rises with the controller still driving the bus; dropping oe (reset)
  // discards it.
  logic [15:0] mem    [0:63];
  int          we_cnt [0:63];
  logic        pend;
  logic [5:0]  pend_a;
  logic [15:0] pend_d;

  assign bif.sram_dq_in = mem[bif.sram_addr[5:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]    <= 16'hA500 | 16'(i);
        we_cnt[i] <= 0;
      end
      pend <= 1'b0;
    end else if (!bif.sram_we_n && bif.sram_dq_oe) begin
      pend   <= 1'b1;
      pend_a <= bif.sram_addr[5:0];
      pend_d <= bif.sram_dq_out;
      we_cnt[bif.sram_addr[5:0]] <= we_cnt[bif.sram_addr[5:0]] + 1;
    end else if (pend && bif.sram_we_n && bif.sram_dq_oe) begin
      mem[pend_a] <= pend_d;
      pend        <= 1'b0;
    end else if (!bif.sram_dq_oe) begin
      pend <= 1'b0;
    end
  end

  int ncmp  = 0;
  int nfail = 0;
  logic [31:0] sb[$];

  // Drive one request, wait for ready, check any read against the scoreboard.
  task automatic run_op(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input bit scramble, output int lat, output int oe_cyc);
    logic [31:0] exp;
    @(posedge clk); #1;
    bif.wr_en = w; bif.rd_en = r; bif.address = a; bif.write_data = d;
    if (r && !w) sb.push_back(exp_rd);
    lat = 0; oe_cyc = 0;
    while (1) begin
      @(negedge clk);
      if (bif.ready) break;
      if (bif.sram_dq_oe) oe_cyc++;
      lat++;
      if (lat > 200) begin
        ncmp++; nfail++;
        $display("FAIL ready_timeout: got no ready, required ready within %0d cycles", LAT);
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        bif.address    = $urandom;
        bif.write_data = $urandom;
      end
    end
    if (r && !w && sb.size() > 0) begin
      exp = sb.pop_front();
      ncmp++;
      if (bif.read_data !== exp) begin
        nfail++;
        $display("FAIL read_data: got %h required %h", bif.read_data, exp);
      end
    end
    @(posedge clk); #1;
    bif.wr_en = 1'b0; bif.rd_en = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    ncmp++;
    if (got !== req) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    bif.wr_en = 1'b0; bif.rd_en = 1'b0; bif.address = '0; bif.write_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(bif.ready), 32'd1);
    chk("reset_we_n", 32'(bif.sram_we_n), 32'd1);
    chk("reset_oe", 32'(bif.sram_dq_oe), 32'd0);
    chk("reset_read_data", bif.read_data, 32'd0);
    chk("reset_sram_addr", 32'(bif.sram_addr), 32'd0);
  endtask

  task automatic test_write();
    int lat, oe, w2, w3;
    w2 = we_cnt[2]; w3 = we_cnt[3];
    run_op(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h0, 1'b1, lat, oe);
    chk("write_latency", 32'(lat), 32'(LAT));
    chk("write_oe_cycles", 32'(oe), 32'(2 * W));
    chk("write_mem2", 32'(mem[2]), 32'h0000BEEF);
    chk("write_mem3", 32'(mem[3]), 32'h0000DEAD);
    chk("write_we_low_lo", 32'(we_cnt[2] - w2), 32'(W - 1));
    chk("write_we_low_hi", 32'(we_cnt[3] - w3), 32'(W - 1));
  endtask

  task automatic test_read();
    int lat, oe;
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 1'b1, lat, oe);
    chk("read_latency", 32'(lat), 32'(LAT));
    chk("read_oe_cycles", 32'(oe), 32'd0);
    repeat (3) @(negedge clk);
    chk("read_data_hold", bif.read_data, 32'hDEADBEEF);
  endtask

  task automatic test_priority();
    int lat, oe, w0, w1;
    w0 = we_cnt[0]; w1 = we_cnt[1];
    run_op(1'b1, 1'b1, 32'd1024, 32'h55AA33CC, 32'h0, 1'b0, lat, oe);
    @(negedge clk);
    chk("prio_latency", 32'(lat), 32'(LAT));
    chk("prio_mem0", 32'(mem[0]), 32'h000033CC);
    chk("prio_mem1", 32'(mem[1]), 32'h000055AA);
    chk("prio_we_low", 32'(we_cnt[0] - w0 + we_cnt[1] - w1), 32'(2 * (W - 1)));
    chk("prio_read_data_kept", bif.read_data, 32'hDEADBEEF);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, w4;
    w4 = we_cnt[4];
    @(posedge clk); #1;
    bif.wr_en = 1'b1; bif.rd_en = 1'b0; bif.address = 32'd1032; bif.write_data = 32'hA1B2C3D4;
    lat1 = 0;
    while (1) begin
      @(negedge clk);
      if (bif.ready || lat1 > 200) break;
      lat1++;
      @(posedge clk);
    end
    // Next instruction presented in the IDLE cycle right after DONE.
    @(posedge clk); #1;
    bif.write_data = 32'h0F0F1E1E;
    lat2 = 0;
    while (1) begin
      @(negedge clk);
      if (bif.ready || lat2 > 200) break;
      lat2++;
      @(posedge clk);
    end
    @(posedge clk); #1;
    bif.wr_en = 1'b0;
    @(negedge clk);
    chk("b2b_latency1", 32'(lat1), 32'(LAT));
    chk("b2b_latency2", 32'(lat2), 32'(LAT));
    chk("b2b_mem4", 32'(mem[4]), 32'h00001E1E);
    chk("b2b_mem5", 32'(mem[5]), 32'h00000F0F);
    chk("b2b_we_low", 32'(we_cnt[4] - w4), 32'(2 * (W - 1)));
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bif.wr_en = 1'b1; bif.rd_en = 1'b0; bif.address = 32'd1024; bif.write_data = 32'hCAFEF00D;
    // Negedge of cycle W+2: second cycle of the high half, strobe low.
    repeat (W + 3) @(negedge clk);
    chk("mid_in_high_addr", 32'(bif.sram_addr), 32'd1);
    chk("mid_in_high_we_n", 32'(bif.sram_we_n), 32'd0);
    bif.wr_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we_n", 32'(bif.sram_we_n), 32'd1);
    chk("mid_rst_oe", 32'(bif.sram_dq_oe), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_ready_idle", 32'(bif.ready), 32'd1);
    chk("mid_mem0_low_done", 32'(mem[0]), 32'h0000F00D);
    chk("mid_mem1_untouched", 32'(mem[1]), 32'h000055AA);
    chk("mid_read_data_cleared", bif.read_data, 32'd0);
  endtask

`ifdef SRAM_READ_CACHE_EN
  task automatic test_cache();
    int lat, oe;
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 1'b0, lat, oe);
    chk("cache_miss_latency", 32'(lat), 32'(LAT));
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 1'b0, lat, oe);
    chk("cache_hit_latency", 32'(lat), 32'd0);
    run_op(1'b1, 1'b0, 32'd1028, 32'h12345678, 32'h0, 1'b0, lat, oe);
    chk("cache_write_latency", 32'(lat), 32'(LAT));
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678, 1'b0, lat, oe);
    chk("cache_wt_hit_latency", 32'(lat), 32'd0);
  endtask
`else
  task automatic test_repeat_read();
    int lat, oe;
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 1'b0, lat, oe);
    chk("reread1_latency", 32'(lat), 32'(LAT));
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 1'b0, lat, oe);
    chk("reread2_latency", 32'(lat), 32'(LAT));
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_back_to_back();
    test_reset_mid();
`ifdef SRAM_READ_CACHE_EN
    test_cache();
`else
    test_repeat_read();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
